// File: rtl/fifo_in_packer.sv
// Packs a stream of 32-bit words into 256-bit words for a FIFO write port.
// A flush pulse closes a partial word with zero padding in the unfilled upper lanes.
module fifo_in_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 out_full,
    output logic                 out_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [2:0]           lane_cnt,
    output logic [CNT_WIDTH-1:0] pack_cnt
);
    localparam int RATIO = OUT_WIDTH / IN_WIDTH;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Handshake: a word moves on every clk edge where in_valid and in_ready are both high;
    // the downstream FIFO takes out_data on every clk edge where out_en is high.
    logic [0:0]           state;
    logic [OUT_WIDTH-1:0] pack_reg;
    logic [OUT_WIDTH-1:0] out_buf;
    logic                 out_vld;
    logic                 last_lane;
    logic                 accept;
    logic                 word_done;
    logic                 buf_free;
    logic                 flush_load;
    logic                 flush_go;
    logic [7:0]           lane_base;

    assign last_lane = (lane_cnt == 3'(RATIO - 1));
    assign out_en    = out_vld & ~out_full & ~rst;
    assign out_data  = out_buf;
    assign in_ready  = ~rst & (state == ST_FILL) & (~last_lane | ~out_vld | ~out_full);

    assign accept     = in_valid & in_ready;
    assign word_done  = accept & last_lane;
    assign buf_free   = ~out_vld | out_en;
    assign flush_load = (state == ST_FLUSH) & buf_free;
    // A flush that lands on the completing lane has nothing left to pad.
    assign flush_go   = (state == ST_FILL) & flush & ~word_done & ((lane_cnt != 3'd0) | accept);
    assign lane_base  = {lane_cnt, 5'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FILL;
            pack_reg <= '0;
            out_buf  <= '0;
            out_vld  <= 1'b0;
            lane_cnt <= 3'd0;
            pack_cnt <= '0;
        end else begin
            if (word_done || flush_load) begin
                out_vld <= 1'b1;
            end else if (out_en) begin
                out_vld <= 1'b0;
            end

            if (out_en) begin
                pack_cnt <= pack_cnt + 1'b1;
            end

            if (word_done) begin
                out_buf  <= {in_data, pack_reg[OUT_WIDTH-IN_WIDTH-1:0]};
                pack_reg <= '0;
                lane_cnt <= 3'd0;
            end else if (accept) begin
                pack_reg[lane_base +: IN_WIDTH] <= in_data;
                lane_cnt <= lane_cnt + 3'd1;
            end

            // Unfilled lanes of pack_reg are already zero, so the padded word is pack_reg as is.
            if (flush_load) begin
                out_buf  <= pack_reg;
                pack_reg <= '0;
                lane_cnt <= 3'd0;
                state    <= ST_FILL;
            end else if (flush_go) begin
                state <= ST_FLUSH;
            end
        end
    end
endmodule

// File: tb/tb_fifo_in_packer.sv
// Bench for fifo_in_packer: a queue-based model of lanes and pending packed words
// checked every cycle, plus directed literal checks and a randomized phase.
module tb_fifo_in_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic         out_full = 1'b0;
    logic         out_en;
    logic [255:0] out_data;
    logic [2:0]   lane_cnt;
    logic [15:0]  pack_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_in_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .out_full (out_full),
        .out_en   (out_en),
        .out_data (out_data),
        .lane_cnt (lane_cnt),
        .pack_cnt (pack_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [31:0]  lanes[$];
    logic [255:0] exp_q[$];
    bit           m_flushing = 1'b0;
    logic [15:0]  m_cnt = '0;
    logic [255:0] last_word = '0;
    int           n_out = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [255:0] pack_lanes();
        logic [255:0] w = '0;
        foreach (lanes[i]) w[i*32 +: 32] = lanes[i];
        return w;
    endfunction

    always @(negedge clk) begin
        logic e_en;
        logic e_rdy;
        bit   done;
        e_en  = !rst && (exp_q.size() > 0) && !out_full;
        e_rdy = !rst && !m_flushing && ((lanes.size() != 7) || (exp_q.size() == 0) || !out_full);
        chk("out_en", out_en, e_en);
        chk("in_ready", in_ready, e_rdy);
        chk("lane_cnt", lane_cnt, lanes.size());
        chk("pack_cnt", pack_cnt, m_cnt);
        if (e_en && out_en) chk("out_data", out_data, exp_q[0]);
        if (out_en) begin
            last_word = out_data;
            n_out++;
        end
        if (rst) begin
            lanes.delete();
            exp_q.delete();
            m_flushing = 1'b0;
            m_cnt = '0;
            n_out = 0;
        end else begin
            if (e_en) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (m_flushing) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back(pack_lanes());
                    lanes.delete();
                    m_flushing = 1'b0;
                end
            end else begin
                done = 1'b0;
                if (in_valid && e_rdy) begin
                    lanes.push_back(in_data);
                    if (lanes.size() == 8) begin
                        exp_q.push_back(pack_lanes());
                        lanes.delete();
                        done = 1'b1;
                    end
                end
                if (flush && !done && lanes.size() != 0) m_flushing = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit fl);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        for (int i = 0; i < 200; i++) begin
            #2;
            ok = in_ready;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (ok) break;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout at %0t: word %0h not accepted within 200 cycles", $time, d);
        end
    endtask

    task automatic flush_pulse();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        do_reset(2);
        chk("reset_out_data", out_data, '0);
        chk("reset_lane_cnt", lane_cnt, 3'd0);
        chk("reset_pack_cnt", pack_cnt, 16'd0);

        // Eight words back to back.
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        idle(3);
        chk("t1_word", last_word, {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
        chk("t1_pack_cnt", pack_cnt, 16'd1);

        // 64 words continuous.
        do_reset(1);
        for (int i = 0; i < 64; i++) send(32'h100 + 32'(i), 1'b0);
        idle(3);
        chk("t2_pack_cnt", pack_cnt, 16'd8);
        chk("t2_n_out", n_out, 8);
        chk("t2_last_word", last_word, {32'h13f, 32'h13e, 32'h13d, 32'h13c, 32'h13b, 32'h13a, 32'h139, 32'h138});

        // Backpressure: 15 words go in under out_full, the 16th waits.
        do_reset(1);
        out_full = 1'b1;
        for (int i = 1; i <= 15; i++) send(32'h300 + 32'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h310;
        repeat (3) step();
        chk("t3_ready_low", in_ready, 1'b0);
        chk("t3_lane_cnt", lane_cnt, 3'd7);
        out_full = 1'b0;
        send(32'h310, 1'b0);
        idle(3);
        chk("t3_pack_cnt", pack_cnt, 16'd2);
        chk("t3_last_word", last_word, {32'h310, 32'h30f, 32'h30e, 32'h30d, 32'h30c, 32'h30b, 32'h30a, 32'h309});

        // Flush of a 3-lane partial word, then a no-op flush.
        do_reset(1);
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b0);
        flush_pulse();
        idle(4);
        chk("t4_word", last_word, {160'h0, 32'hC, 32'hB, 32'hA});
        chk("t4_lane_cnt", lane_cnt, 3'd0);
        chk("t4_pack_cnt", pack_cnt, 16'd1);
        flush_pulse();
        idle(4);
        chk("t4_noop_flush", pack_cnt, 16'd1);

        // Flush together with lane 7, then flush together with lane 2.
        do_reset(1);
        for (int i = 0; i < 7; i++) send(32'h40 + 32'(i), 1'b0);
        send(32'h47, 1'b1);
        idle(4);
        chk("t5_lane7_flush", pack_cnt, 16'd1);
        send(32'h21, 1'b0);
        send(32'h22, 1'b0);
        send(32'h23, 1'b1);
        idle(4);
        chk("t5_lane2_word", last_word, {160'h0, 32'h23, 32'h22, 32'h21});
        chk("t5_pack_cnt", pack_cnt, 16'd2);

        // Reset with a pending word held by out_full and a partial word.
        do_reset(1);
        out_full = 1'b1;
        for (int i = 0; i < 13; i++) send(32'h60 + 32'(i), 1'b0);
        idle(2);
        do_reset(1);
        out_full = 1'b0;
        idle(3);
        chk("t6_no_out", n_out, 0);
        chk("t6_lane_cnt", lane_cnt, 3'd0);
        chk("t6_pack_cnt", pack_cnt, 16'd0);
        for (int i = 0; i < 8; i++) send(32'h50 + 32'(i), 1'b0);
        idle(3);
        chk("t6_fresh_word", last_word, {32'h57, 32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51, 32'h50});

        // Randomized traffic with flushes, backpressure bursts and occasional resets.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) out_full = ~out_full;
            rst      = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        out_full = 1'b0;
        idle(4);
        flush_pulse();
        idle(6);
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_lane_cnt", lane_cnt, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
